// File: rtl/uart_cmd_serializer_if.sv
// Command/UART bundle between the command master, the serializer and the UART TX/RX.
// The slave modport is the serializer's view; master is the surrounding logic.
interface uart_cmd_serializer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_PKT_LEN = 16
);
    logic [CMD_PKT_LEN-1:0] cmd;
    logic                   uart_valid;
    logic                   uart_ready;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   tx_en;
    logic                   tx_done;
    logic [DATA_WIDTH-1:0]  rx_data;
    logic                   rx_valid;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_valid;
    logic                   rsp_err;
    logic                   busy;

    modport slave (
        input  cmd, uart_valid, tx_done, rx_data, rx_valid,
        output uart_ready, tx_data, tx_en, rsp_data, rsp_valid, rsp_err, busy
    );

    modport master (
        output cmd, uart_valid, tx_done, rx_data, rx_valid,
        input  uart_ready, tx_data, tx_en, rsp_data, rsp_valid, rsp_err, busy
    );
endinterface

// File: rtl/uart_cmd_serializer.sv
// Serialises one command MSB-byte-first (optional SOF) into a UART transmitter and,
// for reads, waits for a single reply byte with a timeout.
//
// state     | meaning
// IDLE      | ready for a command
// SEND      | tx_en pulse for the current character
// WAIT_DONE | waiting for the transmitter to finish the character
// WAIT_RSP  | read issued, waiting for reply byte or timeout
module uart_cmd_serializer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CMD_PKT_LEN = 16,
    parameter int                    SOF_EN      = 1,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = 8'hA5,
    parameter int                    RSP_TIMEOUT = 50_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cmd_serializer_if.slave  bus
);
    localparam int NBYTES = CMD_PKT_LEN / DATA_WIDTH;
    // one extra count slot so NBYTES+SOF_EN always fits, even for single-byte commands
    localparam int CW = $clog2(NBYTES + SOF_EN + 1);
    localparam int TW = $clog2(RSP_TIMEOUT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NBYTES + SOF_EN);
    localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, WAIT_RSP} state_t;

    state_t                  state_q, state_d;
    logic [CMD_PKT_LEN-1:0]  shreg_q;
    logic [CW-1:0]           cnt_q;
    logic [TW-1:0]           timer_q;
    logic                    rw_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;

    logic accept, done_ev, last_char, timeout;

    assign accept    = (state_q == IDLE) && bus.uart_valid;
    assign done_ev   = (state_q == WAIT_DONE) && bus.tx_done;
    assign last_char = (cnt_q == CW'(1));
    assign timeout   = (timer_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.uart_valid) state_d = SEND;
            SEND:      state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    if (!last_char) state_d = SEND;
                    else if (rw_q)  state_d = IDLE;
                    else            state_d = WAIT_RSP;
                end
            end
            WAIT_RSP:  if (bus.rx_valid || timeout) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.uart_ready = 1'b0;
        bus.tx_en      = 1'b0;
        bus.busy       = 1'b1;
        case (state_q)
            IDLE: begin
                bus.uart_ready = rst_n;
                bus.busy       = 1'b0;
            end
            SEND:    bus.tx_en = 1'b1;
            default: ;
        endcase
    end

    // the next character is loaded on the way into SEND so tx_data is stable during tx_en
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            rw_q        <= 1'b0;
            tx_data_q   <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (accept) begin
                cnt_q <= CNT_LOAD;
                rw_q  <= bus.cmd[CMD_PKT_LEN-1];
                if (SOF_EN != 0) begin
                    tx_data_q <= SOF_BYTE;
                    shreg_q   <= bus.cmd;
                end else begin
                    tx_data_q <= bus.cmd[CMD_PKT_LEN-1 -: DATA_WIDTH];
                    shreg_q   <= bus.cmd << DATA_WIDTH;
                end
            end
            if (done_ev) begin
                cnt_q   <= cnt_q - CW'(1);
                timer_q <= '0;
                if (!last_char) begin
                    tx_data_q <= shreg_q[CMD_PKT_LEN-1 -: DATA_WIDTH];
                    shreg_q   <= shreg_q << DATA_WIDTH;
                end
            end
            if (state_q == WAIT_RSP) begin
                timer_q <= timer_q + TW'(1);
                if (bus.rx_valid) begin
                    rsp_data_q  <= bus.rx_data;
                    rsp_valid_q <= 1'b1;
                end else if (timeout) begin
                    rsp_data_q  <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_uart_cmd_serializer.sv
// Bench for uart_cmd_serializer: a 16-bit/SOF instance and a 32-bit/no-SOF instance,
// both with a 20-cycle reply timeout, checked against a byte-list reference model.
module tb_uart_cmd_serializer;
    localparam int RSP_T = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_serializer_if #(.DATA_WIDTH(8), .CMD_PKT_LEN(16)) ia ();
    uart_cmd_serializer_if #(.DATA_WIDTH(8), .CMD_PKT_LEN(32)) ib ();

    uart_cmd_serializer #(.DATA_WIDTH(8), .CMD_PKT_LEN(16), .SOF_EN(1),
                          .SOF_BYTE(8'hA5), .RSP_TIMEOUT(RSP_T))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    uart_cmd_serializer #(.DATA_WIDTH(8), .CMD_PKT_LEN(32), .SOF_EN(0),
                          .SOF_BYTE(8'hA5), .RSP_TIMEOUT(RSP_T))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    logic        sel = 1'b0;
    logic [31:0] drv_cmd = '0;
    logic        drv_valid = 1'b0, drv_tx_done = 1'b0, drv_rx_valid = 1'b0;
    logic [7:0]  drv_rx_data = '0;

    assign ia.cmd        = drv_cmd[15:0];
    assign ia.uart_valid = drv_valid & ~sel;
    assign ia.tx_done    = drv_tx_done & ~sel;
    assign ia.rx_valid   = drv_rx_valid & ~sel;
    assign ia.rx_data    = drv_rx_data;
    assign ib.cmd        = drv_cmd;
    assign ib.uart_valid = drv_valid & sel;
    assign ib.tx_done    = drv_tx_done & sel;
    assign ib.rx_valid   = drv_rx_valid & sel;
    assign ib.rx_data    = drv_rx_data;

    logic       o_ready, o_tx_en, o_rsp_valid, o_rsp_err, o_busy;
    logic [7:0] o_tx_data, o_rsp_data;
    assign o_ready     = sel ? ib.uart_ready : ia.uart_ready;
    assign o_tx_en     = sel ? ib.tx_en      : ia.tx_en;
    assign o_rsp_valid = sel ? ib.rsp_valid  : ia.rsp_valid;
    assign o_rsp_err   = sel ? ib.rsp_err    : ia.rsp_err;
    assign o_busy      = sel ? ib.busy       : ia.busy;
    assign o_tx_data   = sel ? ib.tx_data    : ia.tx_data;
    assign o_rsp_data  = sel ? ib.rsp_data   : ia.rsp_data;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // observations from the last frame
    logic [7:0] cap [8];
    int         nb, terr, rsp_cnt, rsp_at;
    logic [7:0] rsp_d;
    logic       rsp_e, rdy0, rdy1, rdy_rsp;

    // Drives one command, plays the transmitter (random 1..4 cycle character time),
    // then watches 30 cycles for the reply while pulsing rx_valid rx_d cycles after the last done.
    task automatic frame(input bit s, input logic [31:0] c, input int rx_d,
                         input logic [7:0] rx_b, input bit early);
        int exp_n, w, lat;
        exp_n = s ? 4 : 3;
        sel = s; nb = 0; terr = 0; rsp_cnt = 0; rsp_at = -1;
        rsp_d = '0; rsp_e = 1'b0; rdy_rsp = 1'b0;
        @(negedge clk);
        rdy0 = o_ready;
        drv_cmd = c; drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0; drv_cmd = $urandom;
        for (int k = 0; k < exp_n; k++) begin
            w = 0;
            while (!o_tx_en && w < 10) begin @(negedge clk); w++; end
            if (!o_tx_en) begin terr++; break; end
            if (w != 0) terr++;
            cap[k] = o_tx_data; nb++;
            if (early && k == 0) begin
                drv_tx_done = 1'b1;
                @(negedge clk);
                drv_tx_done = 1'b0;
            end
            lat = $urandom_range(1, 4);
            repeat (lat) begin @(negedge clk); if (o_tx_en) terr++; end
            drv_tx_done = 1'b1;
            @(negedge clk);
            drv_tx_done = 1'b0;
        end
        rdy1 = o_ready;
        for (int j = 1; j <= 30; j++) begin
            if (j > 1) @(negedge clk);
            if (o_tx_en) terr++;
            if (o_rsp_valid) begin
                rsp_cnt++;
                if (rsp_at < 0) begin
                    rsp_at = j; rsp_d = o_rsp_data; rsp_e = o_rsp_err; rdy_rsp = o_ready;
                end
            end else if (o_rsp_err) terr++;
            drv_rx_valid = (j == rx_d);
            drv_rx_data  = (j == rx_d) ? rx_b : 8'($urandom);
        end
        drv_rx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_n, input logic [31:0] eb,
                               input int exp_at, input logic [7:0] ed, input bit ee);
        chk({tag, " ready_idle"}, 32'(rdy0), 32'd1);
        chk({tag, " ntx"}, nb, exp_n);
        for (int i = 0; i < exp_n && i < nb; i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(cap[i]), 32'(eb[31-8*i -: 8]));
        chk({tag, " timing"}, terr, 0);
        chk({tag, " rsp_count"}, rsp_cnt, (exp_at > 0) ? 1 : 0);
        chk({tag, " ready_after_done"}, 32'(rdy1), (exp_at > 0) ? 32'd0 : 32'd1);
        if (exp_at > 0) begin
            chk({tag, " rsp_cycle"}, rsp_at, exp_at);
            chk({tag, " rsp_data"}, 32'(rsp_d), 32'(ed));
            chk({tag, " rsp_err"}, 32'(rsp_e), 32'(ee));
            chk({tag, " ready_at_rsp"}, 32'(rdy_rsp), 32'd1);
        end
    endtask

    // Reference: the frame is [SOF] followed by the command bytes, most significant first.
    function automatic logic [7:0] model_byte(input bit s, input logic [31:0] c, input int i);
        int nbytes, sof;
        nbytes = s ? 4 : 2;
        sof    = s ? 0 : 1;
        if (sof == 1 && i == 0) return 8'hA5;
        return 8'((c >> (8 * (nbytes - 1 - (i - sof)))) & 32'hFF);
    endfunction

    typedef struct {
        bit          s;
        logic [31:0] cmd;
        int          rx_d;
        logic [7:0]  rx_b;
        bit          early;
        int          exp_n;
        logic [31:0] exp_bytes;
        int          exp_at;
        logic [7:0]  exp_d;
        bit          exp_e;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq [3];
        int ntx, viol, cd, spur;
        bit outstanding;

        tbl[0] = '{0, 32'h85A3, 5,  8'h77, 0, 3, 32'hA585A300, 0,  8'h00, 0};
        tbl[1] = '{0, 32'h1200, 10, 8'h3C, 0, 3, 32'hA5120000, 11, 8'h3C, 0};
        tbl[2] = '{0, 32'h0042, 30, 8'h99, 0, 3, 32'hA5004200, 21, 8'h00, 1};
        tbl[3] = '{0, 32'h7F01, 20, 8'h81, 0, 3, 32'hA57F0100, 21, 8'h81, 0};
        tbl[4] = '{0, 32'h3456, 21, 8'h55, 0, 3, 32'hA5345600, 21, 8'h00, 1};
        tbl[5] = '{0, 32'hC3C3, 2,  8'h11, 1, 3, 32'hA5C3C300, 0,  8'h00, 0};
        tbl[6] = '{1, 32'hDEADBEEF, 3,  8'h22, 0, 4, 32'hDEADBEEF, 0, 8'h00, 0};
        tbl[7] = '{1, 32'h12345678, 1,  8'hE7, 0, 4, 32'h12345678, 2, 8'hE7, 0};
        tbl[8] = '{1, 32'h00000000, 25, 8'h66, 1, 4, 32'h00000000, 21, 8'h00, 1};

        // reset state of both instances
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset%0d uart_ready", s), 32'(o_ready), 32'd0);
            chk($sformatf("reset%0d tx_en", s), 32'(o_tx_en), 32'd0);
            chk($sformatf("reset%0d busy", s), 32'(o_busy), 32'd0);
            chk($sformatf("reset%0d rsp", s),
                {o_rsp_valid, o_rsp_err, o_tx_data, o_rsp_data}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            frame(tbl[i].s, tbl[i].cmd, tbl[i].rx_d, tbl[i].rx_b, tbl[i].early);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_n, tbl[i].exp_bytes,
                        tbl[i].exp_at, tbl[i].exp_d, tbl[i].exp_e);
        end

        for (int r = 0; r < 60; r++) begin
            bit          s, rw;
            logic [31:0] c, eb;
            int          d, en, at;
            logic [7:0]  b, ed;
            bit          ee;
            s  = 1'($urandom_range(0, 1));
            c  = $urandom;
            d  = $urandom_range(1, 26);
            b  = 8'($urandom);
            en = s ? 4 : 3;
            eb = '0;
            for (int i = 0; i < en; i++) eb[31-8*i -: 8] = model_byte(s, c, i);
            rw = s ? c[31] : c[15];
            if (rw)             begin at = 0;         ed = 8'h00; ee = 1'b0; end
            else if (d <= RSP_T) begin at = d + 1;     ed = b;     ee = 1'b0; end
            else                begin at = RSP_T + 1; ed = 8'h00; ee = 1'b1; end
            frame(s, c, d, b, 1'b0);
            check_frame($sformatf("rnd%0d", r), en, eb, at, ed, ee);
        end

        // reset in the middle of a frame, then spurious inputs while idle
        sel = 1'b0;
        @(negedge clk);
        drv_cmd = 32'h9ABC; drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        chk("midrst first tx_en", 32'(o_tx_en), 32'd1);
        @(negedge clk);
        drv_tx_done = 1'b1;
        @(negedge clk);
        drv_tx_done = 1'b0;
        chk("midrst second tx_en", {o_tx_en, o_tx_data}, {1'b1, 8'h9A});
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst outputs",
            {o_ready, o_tx_en, o_busy, o_rsp_valid, o_rsp_err, o_tx_data, o_rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst ready after release", 32'(o_ready), 32'd1);
        drv_tx_done = 1'b1; drv_rx_valid = 1'b1; drv_rx_data = 8'hFF;
        @(negedge clk);
        drv_tx_done = 1'b0; drv_rx_valid = 1'b0;
        spur = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_tx_en || o_busy || o_rsp_valid || !o_ready) spur++;
        end
        chk("midrst idle quiet", spur, 0);

        // uart_valid held high: frames follow back to back, one tx_en per tx_done
        seq[0] = 8'hA5; seq[1] = 8'h80; seq[2] = 8'h01;
        drv_cmd = 32'h8001; drv_valid = 1'b1;
        ntx = 0; viol = 0; cd = -1; outstanding = 1'b0;
        for (int it = 0; it < 90; it++) begin
            @(negedge clk);
            drv_tx_done = 1'b0;
            if (it == 60) drv_valid = 1'b0;
            if (o_rsp_valid) viol++;
            if (o_tx_en) begin
                if (outstanding) viol++;
                if (o_tx_data !== seq[ntx % 3]) viol++;
                outstanding = 1'b1;
                ntx++;
                cd = 2;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin drv_tx_done = 1'b1; outstanding = 1'b0; cd = -1; end
            end
        end
        drv_tx_done = 1'b0;
        chk("b2b protocol violations", viol, 0);
        chk("b2b whole frames", ntx % 3, 0);
        chk("b2b enough frames", 32'(ntx >= 9), 32'd1);
        chk("b2b idle at end", {o_busy, o_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
